// File: rtl/con_cmd_rx.sv
// con_cmd_rx: assembles 4-byte console command frames, validates them,
// starts the console controller and returns one status byte per frame.
module con_cmd_rx #(
  parameter logic [7:0]  HDR        = 8'hA5,
  parameter logic [15:0] RX_GAP_MAX = 16'd50000,
  parameter logic [15:0] EXEC_TMO   = 16'd65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_rx_vld,
  input  logic [7:0]  i_rx_data,
  output logic        o_start_con,
  output logic [11:0] om_base_addr,
  input  logic        i_done_con,
  input  logic        i_error_con,
  output logic        o_tx_vld,
  output logic [7:0]  o_tx_data,
  input  logic        i_tx_rdy,
  output logic        o_busy,
  output logic        o_rx_drop
);

  localparam int unsigned CNT_W = 16;

  localparam logic [7:0] ST_OK    = 8'h5A;
  localparam logic [7:0] ST_ERR   = 8'hEE;
  localparam logic [7:0] ST_TMO   = 8'hE7;
  localparam logic [7:0] ST_CKSUM = 8'hEC;
  localparam logic [7:0] ST_ADDR  = 8'hEA;

  typedef enum logic [6:0] {
    S_HUNT   = 7'b000_0001,
    S_GET_AH = 7'b000_0010,
    S_GET_AL = 7'b000_0100,
    S_GET_CK = 7'b000_1000,
    S_START  = 7'b001_0000,
    S_WAIT   = 7'b010_0000,
    S_RESP   = 7'b100_0000
  } state_t;

  state_t             state_q, state_d;
  logic [7:0]         ah_q, al_q;
  logic [CNT_W-1:0]   gap_cnt_q, exec_cnt_q;

  logic               in_frame;
  logic               in_busy;
  logic               gap_expired;
  logic               exec_expired;
  logic               addr_bad;
  logic               cksum_bad;

  logic               start_d;
  logic [11:0]        addr_d;
  logic               tx_vld_d;
  logic [7:0]         status_d;
  logic               busy_d;
  logic               drop_d;

  assign in_frame     = (state_q == S_GET_AH) || (state_q == S_GET_AL) || (state_q == S_GET_CK);
  assign in_busy      = (state_q == S_START) || (state_q == S_WAIT) || (state_q == S_RESP);
  assign gap_expired  = (gap_cnt_q == RX_GAP_MAX);
  assign exec_expired = (exec_cnt_q == EXEC_TMO);
  assign addr_bad     = (ah_q[7:4] != 4'h0);
  assign cksum_bad    = (i_rx_data != (HDR ^ ah_q ^ al_q));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_HUNT;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_HUNT:   if (i_rx_vld && (i_rx_data == HDR)) state_d = S_GET_AH;
      S_GET_AH: if (i_rx_vld) state_d = S_GET_AL;
                else if (gap_expired) state_d = S_HUNT;
      S_GET_AL: if (i_rx_vld) state_d = S_GET_CK;
                else if (gap_expired) state_d = S_HUNT;
      S_GET_CK: if (i_rx_vld) state_d = (addr_bad || cksum_bad) ? S_RESP : S_START;
                else if (gap_expired) state_d = S_HUNT;
      S_START:  state_d = S_WAIT;
      S_WAIT:   if (i_done_con || i_error_con || exec_expired) state_d = S_RESP;
      S_RESP:   if (i_tx_rdy) state_d = S_HUNT;
      default:  state_d = S_HUNT;
    endcase
  end

  // Output and status next values; registered below
  always_comb begin
    status_d = o_tx_data;
    addr_d   = om_base_addr;
    start_d  = (state_q == S_START);
    tx_vld_d = (state_d == S_RESP);
    busy_d   = (state_d != S_HUNT);
    drop_d   = i_rx_vld && in_busy;
    if ((state_q == S_GET_CK) && i_rx_vld) begin
      if (addr_bad)       status_d = ST_ADDR;
      else if (cksum_bad) status_d = ST_CKSUM;
      else                addr_d   = {ah_q[3:0], al_q};
    end
    if (state_q == S_WAIT) begin
      if (i_done_con)        status_d = ST_OK;
      else if (i_error_con)  status_d = ST_ERR;
      else if (exec_expired) status_d = ST_TMO;
    end
  end

  // Registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_start_con  <= 1'b0;
      om_base_addr <= 12'h000;
      o_tx_vld     <= 1'b0;
      o_tx_data    <= 8'h00;
      o_busy       <= 1'b0;
      o_rx_drop    <= 1'b0;
    end else begin
      o_start_con  <= start_d;
      om_base_addr <= addr_d;
      o_tx_vld     <= tx_vld_d;
      o_tx_data    <= status_d;
      o_busy       <= busy_d;
      o_rx_drop    <= drop_d;
    end
  end

  // Address byte capture and saturating gap/exec counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ah_q       <= 8'h00;
      al_q       <= 8'h00;
      gap_cnt_q  <= '0;
      exec_cnt_q <= '0;
    end else begin
      if ((state_q == S_GET_AH) && i_rx_vld) ah_q <= i_rx_data;
      if ((state_q == S_GET_AL) && i_rx_vld) al_q <= i_rx_data;

      if (i_rx_vld || !in_frame)      gap_cnt_q <= '0;
      else if (gap_cnt_q != '1)       gap_cnt_q <= gap_cnt_q + CNT_W'(1);

      if (state_q == S_START)         exec_cnt_q <= '0;
      else if ((state_q == S_WAIT) && (exec_cnt_q != '1))
                                      exec_cnt_q <= exec_cnt_q + CNT_W'(1);
    end
  end

endmodule
